// File: rtl/mult_sched_pkg.sv
// Shared types and constants for the round-robin multiplier scheduler.
package mult_sched_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        RELEASE = 2'd3
    } mult_sched_state_t;

    localparam int DEFAULT_TIMEOUT = 64;

    // Requester index width; a single bit is kept even for N_REQ <= 2.
    function automatic int id_width(input int n_req);
        return (n_req > 2) ? $clog2(n_req) : 1;
    endfunction

endpackage

// File: rtl/mult_rr_arbiter.sv
// Combinational round-robin pick: first high req at or after ptr, wrapping.
module mult_rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int IDW   = 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   ptr,
    output logic [N_REQ-1:0] win_oh,
    output logic [IDW-1:0]   win_idx,
    output logic             win_valid
);

    logic [IDW-1:0] j;

    always_comb begin
        win_oh    = '0;
        win_idx   = '0;
        win_valid = 1'b0;
        j         = '0;
        for (int i = 0; i < N_REQ; i++) begin
            j = IDW'((int'(ptr) + i) % N_REQ);
            if (!win_valid && req[j]) begin
                win_valid = 1'b1;
                win_idx   = j;
                win_oh[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mult_scheduler.sv
// Shares one sequential multiplier between N_REQ requesters in round-robin order.
// Optional feature: define MULT_SCHED_TIMEOUT_EN to abort WAIT after TIMEOUT cycles.
module mult_scheduler
    import mult_sched_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic [N_REQ-1:0]             req,
    input  logic [N_REQ*WIDTH-1:0]       req_a,
    input  logic [N_REQ*WIDTH-1:0]       req_b,
    output logic [N_REQ-1:0]             gnt,
    output logic [N_REQ-1:0]             done,
    output logic [2*WIDTH-1:0]           result,
    output logic [id_width(N_REQ)-1:0]   result_id,
    output logic                         err,
    output logic                         mult_start,
    output logic [WIDTH-1:0]             mult_a,
    output logic [WIDTH-1:0]             mult_b,
    input  logic                         mult_end,
    input  logic [2*WIDTH-1:0]           mult_product
);

    localparam int IDW = id_width(N_REQ);

    // Handshakes: req acts as valid and must hold with stable operands until gnt;
    // gnt is a one-cycle accept, operands are captured on the edge that raises it.
    // Toward the multiplier, mult_start is held high until mult_end is seen, and
    // a new mult_start is only issued after mult_end has returned low.

    mult_sched_state_t state, next_state;

    logic [IDW-1:0]     ptr, ptr_d;
    logic [IDW-1:0]     owner, owner_d;
    logic [N_REQ-1:0]   gnt_d, done_d;
    logic [2*WIDTH-1:0] result_d;
    logic [IDW-1:0]     result_id_d;
    logic               mult_start_d;
    logic [WIDTH-1:0]   mult_a_d, mult_b_d;
    logic               timeout_hit;

    logic [N_REQ-1:0]   arb_oh;
    logic [IDW-1:0]     arb_idx;
    logic               arb_valid;

    mult_rr_arbiter #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_arb (
        .req       (req),
        .ptr       (ptr),
        .win_oh    (arb_oh),
        .win_idx   (arb_idx),
        .win_valid (arb_valid)
    );

`ifdef MULT_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wait_cnt;

    // Counter is zero on WAIT entry because it is held clear in every other state.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wait_cnt <= '0;
            err      <= 1'b0;
        end else begin
            wait_cnt <= (state == WAIT) ? wait_cnt + CNT_W'(1) : '0;
            err      <= timeout_hit;
        end
    end

    assign timeout_hit = (state == WAIT) && !mult_end && (wait_cnt == CNT_W'(TIMEOUT - 1));
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state      <= IDLE;
            ptr        <= '0;
            owner      <= '0;
            gnt        <= '0;
            done       <= '0;
            result     <= '0;
            result_id  <= '0;
            mult_start <= 1'b0;
            mult_a     <= '0;
            mult_b     <= '0;
        end else begin
            state      <= next_state;
            ptr        <= ptr_d;
            owner      <= owner_d;
            gnt        <= gnt_d;
            done       <= done_d;
            result     <= result_d;
            result_id  <= result_id_d;
            mult_start <= mult_start_d;
            mult_a     <= mult_a_d;
            mult_b     <= mult_b_d;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (arb_valid) next_state = ISSUE;
            ISSUE:   next_state = WAIT;
            WAIT:    if (mult_end || timeout_hit) next_state = RELEASE;
            RELEASE: if (!mult_end) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        ptr_d        = ptr;
        owner_d      = owner;
        gnt_d        = '0;
        done_d       = '0;
        result_d     = result;
        result_id_d  = result_id;
        mult_start_d = mult_start;
        mult_a_d     = mult_a;
        mult_b_d     = mult_b;
        case (state)
            IDLE: begin
                if (arb_valid) begin
                    gnt_d        = arb_oh;
                    owner_d      = arb_idx;
                    ptr_d        = (arb_idx == IDW'(N_REQ - 1)) ? '0 : arb_idx + IDW'(1);
                    mult_a_d     = req_a[arb_idx*WIDTH +: WIDTH];
                    mult_b_d     = req_b[arb_idx*WIDTH +: WIDTH];
                    mult_start_d = 1'b1;
                end
            end
            WAIT: begin
                // A late mult_end on the final timeout cycle still completes normally.
                if (mult_end) begin
                    result_d      = mult_product;
                    result_id_d   = owner;
                    done_d[owner] = 1'b1;
                    mult_start_d  = 1'b0;
                end else if (timeout_hit) begin
                    result_d      = '0;
                    result_id_d   = owner;
                    done_d[owner] = 1'b1;
                    mult_start_d  = 1'b0;
                end
            end
            default: ;
        endcase
    end

endmodule
